// File: rtl/reg_bank_sweep_if.sv
// Bus bundle for reg_bank_sweep: write port, two read ports, clear request and status.
// The master side drives addresses, data and requests; the slave side returns read data and status.
interface reg_bank_sweep_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 3
);
    logic             WE3;
    logic [SIZE-1:0]  A3;
    logic [WIDTH-1:0] WD3;
    logic [SIZE-1:0]  A1;
    logic [SIZE-1:0]  A2;
    logic             CLR;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             BUSY;
    logic             DROP;

    modport master (
        output WE3, A3, WD3, A1, A2, CLR,
        input  RD1, RD2, BUSY, DROP
    );

    modport slave (
        input  WE3, A3, WD3, A1, A2, CLR,
        output RD1, RD2, BUSY, DROP
    );
endinterface

// File: rtl/reg_bank_sweep.sv
// Register bank of 2**SIZE words with two combinational read ports, one write port and a
// one-word-per-cycle clear sweep. Define REGBANK_BYPASS_EN for same-cycle write forwarding.
module reg_bank_sweep #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      SIZE      = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic             CLK,
    input logic             RST_N,
    reg_bank_sweep_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** SIZE;

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e           state_q, state_d;
    logic [SIZE-1:0]  ptr_q, ptr_d;
    logic             drop_q, drop_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd1, rd2;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        drop_d  = 1'b0;
        mem_d   = mem_q;
        unique case (state_q)
            StIdle: begin
                // A write on the CLR edge still commits; the sweep overwrites it later.
                if (bus.WE3) begin
                    mem_d[bus.A3] = bus.WD3;
                end
                if (bus.CLR) begin
                    state_d = StSweep;
                    ptr_d   = '0;
                end
            end
            StSweep: begin
                mem_d[ptr_q] = RESET_VAL;
                drop_d       = bus.WE3;
                if (&ptr_q) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            drop_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            drop_q  <= drop_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        rd1 = mem_q[bus.A1];
        rd2 = mem_q[bus.A2];
`ifdef REGBANK_BYPASS_EN
        if (bus.WE3 && (state_q == StIdle) && RST_N) begin
            if (bus.A1 == bus.A3) begin
                rd1 = bus.WD3;
            end
            if (bus.A2 == bus.A3) begin
                rd2 = bus.WD3;
            end
        end
`endif
    end

    assign bus.RD1  = rd1;
    assign bus.RD2  = rd2;
    assign bus.BUSY = (state_q == StSweep);
    assign bus.DROP = drop_q;
endmodule
